trap_controller: RTL and testbench



---
 rtl/trap_controller.sv | 143 ++++++++++++++
 tb/tb_trap_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller
//   Vectored trap controller between commit and fetch. It accepts prioritised
//   exception requests, flushes the ROB from the faulting entry, and redirects
//   fetch to a per-cause vector through a valid/ready handshake. It records
//   MEPC/MCAUSE, returns to the saved PC on mret, and flags nested faults.
//
// Ports
//   clk              in   clock
//   reset_n          in   asynchronous active-low reset
//   exc_req          in   per-cause exception request (index 0 = highest priority)
//   exc_pc           in   PC of the faulting instruction
//   exc_rob_ptr      in   ROB index of the faulting instruction
//   mret             in   one-cycle handler return pulse
//   redirect_ready   in   fetch accepts the redirect
//   recover          out  one-cycle ROB flush pulse
//   recover_rob_ptr  out  flush from this ROB entry (inclusive)
//   redirect_valid   out  redirect request to fetch
//   redirect_pc      out  redirect target (0 when not valid)
//   mepc             out  saved faulting PC
//   mcause           out  saved cause
//   trap_active      out  high whenever not IDLE
//   double_fault     out  sticky nested-exception flag
module trap_controller #(
  parameter int          NUM_CAUSES = 4,
  parameter int          CAUSE_W    = 2,
  parameter int          ROB_PTR_W  = 4,
  parameter logic [31:0] TRAP_BASE  = 32'h0000_0080,
  parameter bit          VECTORED   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_CAUSES-1:0] exc_req,
  input  logic [31:0]           exc_pc,
  input  logic [ROB_PTR_W-1:0]  exc_rob_ptr,
  input  logic                  mret,
  input  logic                  redirect_ready,
  output logic                  recover,
  output logic [ROB_PTR_W-1:0]  recover_rob_ptr,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic [31:0]           mepc,
  output logic [CAUSE_W-1:0]    mcause,
  output logic                  trap_active,
  output logic                  double_fault
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    REDIRECT,
    IN_TRAP,
    RETURN
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CAUSE_W-1:0] win_cause;
  logic               any_req;
  logic [31:0]        cause_off;
  logic [31:0]        target;
  logic               accept_exc;

  // Priority encoder: lowest set index wins.
  always_comb begin
    win_cause = '0;
    any_req   = 1'b0;
    for (int unsigned i = 0; i < unsigned'(NUM_CAUSES); i++) begin
      if (exc_req[i] && !any_req) begin
        win_cause = CAUSE_W'(i);
        any_req   = 1'b1;
      end
    end
  end

  assign accept_exc = (state == IDLE) && any_req;

  // Vector target: zero-extended cause scaled by 4, modular 32-bit add.
  always_comb begin
    cause_off                = '0;
    cause_off[CAUSE_W+1:2]   = mcause;
    target                   = VECTORED ? (TRAP_BASE + cause_off) : TRAP_BASE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mepc            <= '0;
      mcause          <= '0;
      recover_rob_ptr <= '0;
      double_fault    <= 1'b0;
    end else begin
      if (accept_exc) begin
        mepc            <= exc_pc;
        mcause          <= win_cause;
        recover_rob_ptr <= exc_rob_ptr;
      end
      // mret takes precedence over a coincident request while in the handler.
      if ((state == IN_TRAP) && any_req && !mret) begin
        double_fault <= 1'b1;
      end
    end
  end

  // Next state and state-decoded outputs; no input reaches an output.
  always_comb begin
    next_state     = state;
    recover        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap_active    = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any_req) next_state = FLUSH;
      end
      FLUSH: begin
        recover    = 1'b1;
        next_state = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
        if (redirect_ready) next_state = IN_TRAP;
      end
      IN_TRAP: begin
        if (mret) next_state = RETURN;
      end
      RETURN: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
        if (redirect_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

  logic        clk;
  logic        reset_n;
  logic [3:0]  exc_req;
  logic [31:0] exc_pc;
  logic [3:0]  exc_rob_ptr;
  logic        mret;
  logic        redirect_ready;

  logic        recover;
  logic [3:0]  recover_rob_ptr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mepc;
  logic [1:0]  mcause;
  logic        trap_active;
  logic        double_fault;

  // Flat-vector instance sharing the same inputs
  logic        f_recover;
  logic [3:0]  f_recover_rob_ptr;
  logic        f_redirect_valid;
  logic [31:0] f_redirect_pc;
  logic [31:0] f_mepc;
  logic [1:0]  f_mcause;
  logic        f_trap_active;
  logic        f_double_fault;

  int checks = 0;
  int errors = 0;

  trap_controller #(
    .NUM_CAUSES(4), .CAUSE_W(2), .ROB_PTR_W(4),
    .TRAP_BASE(32'h0000_0080), .VECTORED(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .exc_req(exc_req), .exc_pc(exc_pc),
    .exc_rob_ptr(exc_rob_ptr), .mret(mret), .redirect_ready(redirect_ready),
    .recover(recover), .recover_rob_ptr(recover_rob_ptr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mepc(mepc), .mcause(mcause), .trap_active(trap_active),
    .double_fault(double_fault)
  );

  trap_controller #(
    .NUM_CAUSES(4), .CAUSE_W(2), .ROB_PTR_W(4),
    .TRAP_BASE(32'h0000_0080), .VECTORED(1'b0)
  ) dut_flat (
    .clk(clk), .reset_n(reset_n), .exc_req(exc_req), .exc_pc(exc_pc),
    .exc_rob_ptr(exc_rob_ptr), .mret(mret), .redirect_ready(redirect_ready),
    .recover(f_recover), .recover_rob_ptr(f_recover_rob_ptr),
    .redirect_valid(f_redirect_valid), .redirect_pc(f_redirect_pc),
    .mepc(f_mepc), .mcause(f_mcause), .trap_active(f_trap_active),
    .double_fault(f_double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    exc_req        = '0;
    exc_pc         = '0;
    exc_rob_ptr    = '0;
    mret           = 1'b0;
    redirect_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (recover !== 1'b0) begin errors++; $display("FAIL reset_recover: got %0b exp 0", recover); end
    checks++; if (recover_rob_ptr !== 4'd0) begin errors++; $display("FAIL reset_ptr: got %0d exp 0", recover_rob_ptr); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", redirect_pc); end
    checks++; if (mepc !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h exp 0", mepc); end
    checks++; if (mcause !== 2'd0) begin errors++; $display("FAIL reset_mcause: got %0d exp 0", mcause); end
    checks++; if (trap_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b exp 0", trap_active); end
    checks++; if (double_fault !== 1'b0) begin errors++; $display("FAIL reset_dfault: got %0b exp 0", double_fault); end
  endtask

  task automatic test_basic_trap();
    exc_req = 4'b0100; exc_pc = 32'h1000; exc_rob_ptr = 4'd5; redirect_ready = 1'b1;
    step(); // FLUSH
    exc_req = '0;
    checks++; if (recover !== 1'b1) begin errors++; $display("FAIL basic_recover: got %0b exp 1", recover); end
    checks++; if (recover_rob_ptr !== 4'd5) begin errors++; $display("FAIL basic_ptr: got %0d exp 5", recover_rob_ptr); end
    checks++; if (mcause !== 2'd2) begin errors++; $display("FAIL basic_mcause: got %0d exp 2", mcause); end
    checks++; if (mepc !== 32'h1000) begin errors++; $display("FAIL basic_mepc: got %h exp 1000", mepc); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_flush: got %0b exp 0", redirect_valid); end
    checks++; if (trap_active !== 1'b1) begin errors++; $display("FAIL basic_active: got %0b exp 1", trap_active); end
    step(); // REDIRECT
    checks++; if (recover !== 1'b0) begin errors++; $display("FAIL basic_recover_once: got %0b exp 0", recover); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b exp 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h88) begin errors++; $display("FAIL basic_target: got %h exp 88", redirect_pc); end
    step(); // IN_TRAP
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL basic_pc_zero: got %h exp 0", redirect_pc); end
    checks++; if (trap_active !== 1'b1) begin errors++; $display("FAIL basic_in_trap: got %0b exp 1", trap_active); end
    mret = 1'b1;
    step(); // RETURN
    mret = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL basic_ret_valid: got %0b exp 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h1000) begin errors++; $display("FAIL basic_ret_pc: got %h exp 1000", redirect_pc); end
    step(); // IDLE
    checks++; if (trap_active !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0b exp 0", trap_active); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %0b exp 0", redirect_valid); end
  endtask

  task automatic test_priority();
    exc_req = 4'b1010; exc_pc = 32'h2000; exc_rob_ptr = 4'd3; redirect_ready = 1'b1;
    step(); // FLUSH
    exc_req = '0;
    checks++; if (mcause !== 2'd1) begin errors++; $display("FAIL prio_mcause: got %0d exp 1", mcause); end
    checks++; if (recover_rob_ptr !== 4'd3) begin errors++; $display("FAIL prio_ptr: got %0d exp 3", recover_rob_ptr); end
    step(); // REDIRECT
    checks++; if (redirect_pc !== 32'h84) begin errors++; $display("FAIL prio_target: got %h exp 84", redirect_pc); end
    checks++; if (f_redirect_pc !== 32'h80) begin errors++; $display("FAIL flat_target: got %h exp 80", f_redirect_pc); end
    checks++; if (f_redirect_valid !== 1'b1) begin errors++; $display("FAIL flat_valid: got %0b exp 1", f_redirect_valid); end
    step(); // IN_TRAP
    mret = 1'b1;
    step(); // RETURN
    mret = 1'b0;
    checks++; if (redirect_pc !== 32'h2000) begin errors++; $display("FAIL prio_ret_pc: got %h exp 2000", redirect_pc); end
    step(); // IDLE
    checks++; if (trap_active !== 1'b0) begin errors++; $display("FAIL prio_idle: got %0b exp 0", trap_active); end
  endtask

  task automatic test_backpressure_double_fault();
    exc_req = 4'b0001; exc_pc = 32'h3000; exc_rob_ptr = 4'd11; redirect_ready = 1'b0;
    step(); // FLUSH
    exc_req = '0;
    step(); // REDIRECT
    for (int i = 0; i < 5; i++) begin
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%0b pc=%h exp valid=1 pc=80", i, redirect_valid, redirect_pc);
      end
      step();
    end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid: got %0b exp 1", redirect_valid); end
    redirect_ready = 1'b1;
    step(); // IN_TRAP
    redirect_ready = 1'b0;
    checks++; if (redirect_valid !== 1'b0 || trap_active !== 1'b1) begin
      errors++; $display("FAIL bp_in_trap: got valid=%0b active=%0b exp valid=0 active=1", redirect_valid, trap_active);
    end
    exc_req = 4'b0001; exc_pc = 32'h9999; exc_rob_ptr = 4'd1;
    step(); // still IN_TRAP, nested fault recorded
    exc_req = '0;
    checks++; if (double_fault !== 1'b1) begin errors++; $display("FAIL df_set: got %0b exp 1", double_fault); end
    checks++; if (mepc !== 32'h3000) begin errors++; $display("FAIL df_mepc: got %h exp 3000", mepc); end
    checks++; if (mcause !== 2'd0) begin errors++; $display("FAIL df_mcause: got %0d exp 0", mcause); end
    checks++; if (recover !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL df_state: got recover=%0b valid=%0b exp 0 0", recover, redirect_valid);
    end
    mret = 1'b1;
    step(); // RETURN
    mret = 1'b0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000) begin
      errors++; $display("FAIL df_ret: got valid=%0b pc=%h exp valid=1 pc=3000", redirect_valid, redirect_pc);
    end
    step(); // RETURN held, ready low
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000) begin
      errors++; $display("FAIL df_ret_hold: got valid=%0b pc=%h exp valid=1 pc=3000", redirect_valid, redirect_pc);
    end
    redirect_ready = 1'b1;
    step(); // IDLE
    checks++; if (trap_active !== 1'b0) begin errors++; $display("FAIL df_idle: got %0b exp 0", trap_active); end
    checks++; if (double_fault !== 1'b1) begin errors++; $display("FAIL df_sticky: got %0b exp 1", double_fault); end
  endtask

  task automatic test_mret_wins();
    do_reset();
    exc_req = 4'b0100; exc_pc = 32'h4000; exc_rob_ptr = 4'd2; redirect_ready = 1'b1;
    step(); // FLUSH
    exc_req = '0;
    step(); // REDIRECT
    step(); // IN_TRAP
    checks++; if (trap_active !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL mw_in_trap: got active=%0b valid=%0b exp 1 0", trap_active, redirect_valid);
    end
    mret = 1'b1; exc_req = 4'b1000;
    step(); // RETURN
    mret = 1'b0; exc_req = '0;
    checks++; if (double_fault !== 1'b0) begin errors++; $display("FAIL mw_no_df: got %0b exp 0", double_fault); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4000) begin
      errors++; $display("FAIL mw_ret: got valid=%0b pc=%h exp valid=1 pc=4000", redirect_valid, redirect_pc);
    end
    checks++; if (mcause !== 2'd2) begin errors++; $display("FAIL mw_mcause: got %0d exp 2", mcause); end
    step(); // IDLE
    mret = 1'b1;
    step(); // mret in IDLE ignored
    mret = 1'b0;
    checks++; if (trap_active !== 1'b0 || redirect_valid !== 1'b0 || recover !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++; $display("FAIL mret_idle: got active=%0b valid=%0b recover=%0b pc=%h exp 0 0 0 0",
                         trap_active, redirect_valid, recover, redirect_pc);
    end
    checks++; if (mepc !== 32'h4000) begin errors++; $display("FAIL mret_idle_mepc: got %h exp 4000", mepc); end
  endtask

  task automatic test_async_reset();
    exc_req = 4'b0010; exc_pc = 32'h5000; exc_rob_ptr = 4'd9; redirect_ready = 1'b0;
    step(); // FLUSH
    exc_req = '0;
    step(); // REDIRECT
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h84) begin
      errors++; $display("FAIL ar_pre: got valid=%0b pc=%h exp valid=1 pc=84", redirect_valid, redirect_pc);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || trap_active !== 1'b0 || recover !== 1'b0) begin
      errors++; $display("FAIL ar_outputs: got valid=%0b pc=%h active=%0b recover=%0b exp 0",
                         redirect_valid, redirect_pc, trap_active, recover);
    end
    checks++; if (mepc !== 32'h0 || mcause !== 2'd0 || recover_rob_ptr !== 4'd0 || double_fault !== 1'b0) begin
      errors++; $display("FAIL ar_regs: got mepc=%h mcause=%0d ptr=%0d df=%0b exp 0",
                         mepc, mcause, recover_rob_ptr, double_fault);
    end
    #2 reset_n = 1'b1;
    exc_req = 4'b0001; exc_pc = 32'h6000; exc_rob_ptr = 4'd7; redirect_ready = 1'b1;
    step(); // FLUSH
    exc_req = '0;
    checks++; if (recover !== 1'b1 || recover_rob_ptr !== 4'd7 || mepc !== 32'h6000) begin
      errors++; $display("FAIL ar_flush: got recover=%0b ptr=%0d mepc=%h exp 1 7 6000", recover, recover_rob_ptr, mepc);
    end
    step(); // REDIRECT
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin
      errors++; $display("FAIL ar_redirect: got valid=%0b pc=%h exp valid=1 pc=80", redirect_valid, redirect_pc);
    end
    step(); // IN_TRAP
    checks++; if (trap_active !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL ar_in_trap: got active=%0b valid=%0b exp 1 0", trap_active, redirect_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_trap();
    test_priority();
    test_backpressure_double_fault();
    test_mret_wins();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
